// File: rtl/imem_load_ctrl.sv
// rtl/imem_load_ctrl.sv - streams source words into instruction-memory lines and writes them out.
// Optional XOR checksum of accepted words: define IMEM_LOAD_CHECKSUM_EN.
module imem_load_ctrl #(
  parameter int WORD_W = 48,
  parameter int WORDS  = 5,
  parameter int ADDR_W = 8
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     start,
  input  logic                     abort,
  input  logic [ADDR_W-1:0]        base_addr,
  input  logic [ADDR_W-1:0]        line_cnt_m1,
  input  logic                     in_valid,
  input  logic [WORD_W-1:0]        in_word,
  output logic                     in_ready,
  output logic                     iMem_WEPin,
  output logic [ADDR_W-1:0]        WEAddress,
  output logic [WORD_W*WORDS-1:0]  idataWrite,
  output logic                     core_hold,
  output logic                     busy,
  output logic                     done,
  output logic [WORD_W-1:0]        checksum
);

  localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

  typedef enum logic [1:0] {IDLE, FILL, WRITE, DONE} state_t;

  state_t                     state_q;
  logic [ADDR_W-1:0]          base_q;
  logic [ADDR_W-1:0]          last_line_q;
  logic [ADDR_W-1:0]          line_idx_q;
  logic [IDX_W-1:0]           word_idx_q;
  logic [WORD_W*WORDS-1:0]    fill_q;
  logic [WORD_W*WORDS-1:0]    data_q;
  logic [ADDR_W-1:0]          addr_q;
  logic [WORD_W*WORDS-1:0]    fill_d;
  logic                       start_acc;
  logic                       word_acc;

  assign start_acc = (state_q == IDLE) && start && !abort;
  assign word_acc  = (state_q == FILL) && in_valid && !abort;

  // Lines assemble in fill_q so the memory-facing data only changes when a write is issued.
  always_comb begin
    fill_d = fill_q;
    fill_d[word_idx_q*WORD_W +: WORD_W] = in_word;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      base_q      <= '0;
      last_line_q <= '0;
      line_idx_q  <= '0;
      word_idx_q  <= '0;
      fill_q      <= '0;
      data_q      <= '0;
      addr_q      <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_acc) begin
            state_q     <= FILL;
            base_q      <= base_addr;
            last_line_q <= line_cnt_m1;
            line_idx_q  <= '0;
            word_idx_q  <= '0;
          end
        end
        FILL: begin
          if (abort) begin
            state_q <= IDLE;
          end else if (word_acc) begin
            fill_q <= fill_d;
            if (word_idx_q == LAST_IDX) begin
              word_idx_q <= '0;
              data_q     <= fill_d;
              addr_q     <= base_q + line_idx_q;
              state_q    <= WRITE;
            end else begin
              word_idx_q <= word_idx_q + 1'b1;
            end
          end
        end
        WRITE: begin
          if (abort) begin
            state_q <= IDLE;
          end else if (line_idx_q == last_line_q) begin
            state_q <= DONE;
          end else begin
            line_idx_q <= line_idx_q + 1'b1;
            state_q    <= FILL;
          end
        end
        DONE: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Abort suppresses the write strobe and done pulse in the very cycle it is raised.
  assign in_ready   = (state_q == FILL);
  assign iMem_WEPin = (state_q == WRITE) && !abort;
  assign done       = (state_q == DONE) && !abort;
  assign busy       = (state_q != IDLE);
  assign core_hold  = busy;
  assign WEAddress  = addr_q;
  assign idataWrite = data_q;

`ifdef IMEM_LOAD_CHECKSUM_EN
  logic [WORD_W-1:0] checksum_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      checksum_q <= '0;
    end else if (start_acc) begin
      checksum_q <= '0;
    end else if (word_acc) begin
      checksum_q <= checksum_q ^ in_word;
    end
  end

  assign checksum = checksum_q;
`else
  assign checksum = '0;
`endif

endmodule

// File: tb/tb_imem_load_ctrl.sv
// tb/tb_imem_load_ctrl.sv - directed self-checking bench for imem_load_ctrl with a line-level write model.
module tb_imem_load_ctrl;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [7:0]    base_addr = '0;
  logic [7:0]    line_cnt_m1 = '0;
  logic          in_valid = 1'b0;
  logic [47:0]   in_word = '0;
  logic          in_ready;
  logic          iMem_WEPin;
  logic [7:0]    WEAddress;
  logic [239:0]  idataWrite;
  logic          core_hold;
  logic          busy;
  logic          done;
  logic [47:0]   checksum;

  imem_load_ctrl dut (
    .clock(clock), .reset_n(reset_n), .start(start), .abort(abort),
    .base_addr(base_addr), .line_cnt_m1(line_cnt_m1),
    .in_valid(in_valid), .in_word(in_word), .in_ready(in_ready),
    .iMem_WEPin(iMem_WEPin), .WEAddress(WEAddress), .idataWrite(idataWrite),
    .core_hold(core_hold), .busy(busy), .done(done), .checksum(checksum)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [7:0]   addr;
    logic [239:0] data;
  } wr_t;

  wr_t          exp_q[$];
  int           we_cyc_log[$];
  logic [7:0]   we_addr_log[$];
  logic [47:0]  words_buf [0:15];
  logic [239:0] last_we_data;
  int           last_we_cyc = -100;
  int           cyc = 0;
  int           we_cnt = 0;
  int           done_cnt = 0;
  int           n_assert = 0;
  int           n_fail = 0;

  task automatic check(input string name, input logic [239:0] act, input logic [239:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [239:0] pack(input int first);
    logic [239:0] d;
    for (int k = 0; k < 5; k++) d[48*k +: 48] = words_buf[first + k];
    return d;
  endfunction

  function automatic logic [47:0] model_ck(input int n);
    logic [47:0] x = '0;
`ifdef IMEM_LOAD_CHECKSUM_EN
    for (int i = 0; i < n; i++) x ^= words_buf[i];
`else
    x = (n > 0) ? 48'd0 : 48'd0;
`endif
    return x;
  endfunction

  // Every completed line of a load lands at (base + line) mod 256, one write per line.
  task automatic push_exp(input logic [7:0] base, input int nlines);
    for (int l = 0; l < nlines; l++) begin
      wr_t e;
      e.addr = base + 8'(l);
      e.data = pack(l * 5);
      exp_q.push_back(e);
    end
  endtask

  always @(negedge clock) begin
    cyc++;
    check("hold_eq_busy", {239'd0, core_hold}, {239'd0, busy});
    if (in_ready && !busy) check("ready_only_busy", 240'd1, 240'd0);
    if (iMem_WEPin) begin
      we_cnt++;
      we_cyc_log.push_back(cyc);
      we_addr_log.push_back(WEAddress);
      last_we_data = idataWrite;
      last_we_cyc  = cyc;
      if (exp_q.size() == 0) begin
        check("unexpected_write", {232'd0, WEAddress}, 240'hFFFF);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        check("we_addr", {232'd0, WEAddress}, {232'd0, e.addr});
        check("we_data", idataWrite, e.data);
      end
    end
    if (done) begin
      done_cnt++;
      check("done_after_write", 240'(cyc), 240'(last_we_cyc + 1));
    end
  end

  task automatic do_start(input logic [7:0] base, input logic [7:0] cm1);
    base_addr = base;
    line_cnt_m1 = cm1;
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
  endtask

  task automatic feed_words(input int n, input bit gap);
    for (int i = 0; i < n; i++) begin
      bit acc = 1'b0;
      int budget = 0;
      while (!acc) begin
        in_valid = 1'b1;
        in_word  = words_buf[i];
        @(negedge clock);
        acc = in_ready;
        @(posedge clock); #1;
        if (!acc) begin
          budget++;
          if (budget > 40) begin
            check("feed_timeout", 240'(budget), 240'd0);
            in_valid = 1'b0;
            return;
          end
        end
      end
      in_valid = 1'b0;
      if (gap) begin
        in_word = 48'hDEAD_BEEF_0000;
        @(posedge clock); #1;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int k = 0;
    do begin
      @(negedge clock);
      k++;
    end while (busy && k < 40);
    if (busy) check("idle_timeout", 240'd1, 240'd0);
    @(posedge clock); #1;
  endtask

  task automatic set_seq_words(input int n);
    for (int i = 0; i < n; i++) words_buf[i] = 48'(i + 1);
  endtask

  initial begin
    logic [239:0] lit_line;
    int w0, d0, ws;

    repeat (2) @(negedge clock);
    check("rst_in_ready", {239'd0, in_ready}, 240'd0);
    check("rst_wepin", {239'd0, iMem_WEPin}, 240'd0);
    check("rst_busy", {239'd0, busy}, 240'd0);
    check("rst_done", {239'd0, done}, 240'd0);
    check("rst_addr", {232'd0, WEAddress}, 240'd0);
    check("rst_data", idataWrite, 240'd0);
    check("rst_ck", {192'd0, checksum}, 240'd0);
    @(posedge clock); #1;
    reset_n = 1'b1;
    @(posedge clock); #1;

    // single line, back-to-back words 1..5
    lit_line = {48'd5, 48'd4, 48'd3, 48'd2, 48'd1};
    set_seq_words(5);
    w0 = we_cnt; d0 = done_cnt;
    push_exp(8'h10, 1);
    do_start(8'h10, 8'd0);
    feed_words(5, 1'b0);
    wait_idle();
    check("b2b_writes", 240'(we_cnt - w0), 240'd1);
    check("b2b_done", 240'(done_cnt - d0), 240'd1);
    check("b2b_addr_lit", {232'd0, WEAddress}, 240'h10);
    check("b2b_data_lit", last_we_data, lit_line);
    check("b2b_ck", {192'd0, checksum}, {192'd0, model_ck(5)});
    check("idle_wepin_low", {239'd0, iMem_WEPin}, 240'd0);

    // three lines wrapping 0xFE..0x00; a stray start while busy must not disturb it
    for (int i = 0; i < 15; i++) words_buf[i] = {16'($urandom), $urandom};
    w0 = we_cnt; d0 = done_cnt; ws = we_cyc_log.size();
    push_exp(8'hFE, 3);
    do_start(8'hFE, 8'd2);
    base_addr = 8'h77; line_cnt_m1 = 8'd0; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    feed_words(15, 1'b0);
    wait_idle();
    check("wrap_writes", 240'(we_cnt - w0), 240'd3);
    check("wrap_done", 240'(done_cnt - d0), 240'd1);
    if (we_cyc_log.size() >= ws + 3) begin
      check("wrap_addr0", {232'd0, we_addr_log[ws]}, 240'hFE);
      check("wrap_addr1", {232'd0, we_addr_log[ws+1]}, 240'hFF);
      check("wrap_addr2", {232'd0, we_addr_log[ws+2]}, 240'h00);
      check("wrap_gap01", 240'(we_cyc_log[ws+1] - we_cyc_log[ws]), 240'd6);
      check("wrap_gap12", 240'(we_cyc_log[ws+2] - we_cyc_log[ws+1]), 240'd6);
    end else begin
      check("wrap_log_len", 240'(we_cyc_log.size() - ws), 240'd3);
    end
    check("wrap_ck", {192'd0, checksum}, {192'd0, model_ck(15)});

    // in_valid toggled every other cycle gives the same line
    set_seq_words(5);
    w0 = we_cnt;
    push_exp(8'h10, 1);
    do_start(8'h10, 8'd0);
    feed_words(5, 1'b1);
    wait_idle();
    check("toggle_writes", 240'(we_cnt - w0), 240'd1);
    check("toggle_data_lit", last_we_data, lit_line);

    // one-hot words for the checksum
    for (int i = 0; i < 5; i++) words_buf[i] = 48'(1) << i;
    push_exp(8'h40, 1);
    do_start(8'h40, 8'd0);
    feed_words(5, 1'b0);
    wait_idle();
`ifdef IMEM_LOAD_CHECKSUM_EN
    check("ck_lit", {192'd0, checksum}, 240'h1F);
`else
    check("ck_lit", {192'd0, checksum}, 240'h0);
`endif

    // abort after word 3 of line 1
    for (int i = 0; i < 10; i++) words_buf[i] = 48'hA000 + 48'(i);
    w0 = we_cnt; d0 = done_cnt;
    push_exp(8'h20, 1);
    do_start(8'h20, 8'd1);
    feed_words(8, 1'b0);
    abort = 1'b1;
    @(negedge clock);
    check("abort_fill_wepin", {239'd0, iMem_WEPin}, 240'd0);
    @(posedge clock); #1;
    abort = 1'b0;
    @(negedge clock);
    check("abort_busy", {239'd0, busy}, 240'd0);
    check("abort_hold", {239'd0, core_hold}, 240'd0);
    check("abort_writes", 240'(we_cnt - w0), 240'd1);
    check("abort_done", 240'(done_cnt - d0), 240'd0);
    @(posedge clock); #1;
    start = 1'b1; abort = 1'b1;
    @(posedge clock); #1;
    start = 1'b0; abort = 1'b0;
    repeat (3) begin
      @(negedge clock);
      check("start_abort_idle", {239'd0, busy}, 240'd0);
    end
    @(posedge clock); #1;

    // abort raised in the WRITE cycle suppresses the write
    w0 = we_cnt; d0 = done_cnt;
    do_start(8'h50, 8'd0);
    feed_words(5, 1'b0);
    abort = 1'b1;
    @(negedge clock);
    check("abort_write_wepin", {239'd0, iMem_WEPin}, 240'd0);
    @(posedge clock); #1;
    abort = 1'b0;
    @(negedge clock);
    check("abort_write_busy", {239'd0, busy}, 240'd0);
    check("abort_write_cnt", 240'(we_cnt - w0), 240'd0);
    check("abort_write_done", 240'(done_cnt - d0), 240'd0);
    @(posedge clock); #1;

    // reset pulse during WRITE
    w0 = we_cnt;
    do_start(8'h30, 8'd0);
    feed_words(5, 1'b0);
    reset_n = 1'b0;
    #1;
    check("rstw_wepin", {239'd0, iMem_WEPin}, 240'd0);
    check("rstw_busy", {239'd0, busy}, 240'd0);
    check("rstw_hold", {239'd0, core_hold}, 240'd0);
    check("rstw_ready", {239'd0, in_ready}, 240'd0);
    check("rstw_done", {239'd0, done}, 240'd0);
    check("rstw_addr", {232'd0, WEAddress}, 240'd0);
    check("rstw_data", idataWrite, 240'd0);
    check("rstw_ck", {192'd0, checksum}, 240'd0);
    @(posedge clock); #1;
    reset_n = 1'b1;
    repeat (3) begin
      @(negedge clock);
      check("rstw_stays_idle", {239'd0, busy}, 240'd0);
    end
    check("rstw_no_write", 240'(we_cnt - w0), 240'd0);
    check("exp_q_empty", 240'(exp_q.size()), 240'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/imem_load_ctrl.md
IMEM_LOAD_CTRL -- requirements
Module: imem_load_ctrl

Interface
REQ-001 SHALL have parameter WORD_W, default 48: width of one instruction-memory word slot.
REQ-002 SHALL have parameter WORDS, default 5: word slots per memory line; line width = WORD_W*WORDS = 240.
REQ-003 SHALL have parameter ADDR_W, default 8: instruction-memory line address width.
REQ-004 SHALL have port clock  input  1  the single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port start  input  1  one-cycle load request; sampled only in IDLE.
REQ-007 SHALL have port abort  input  1  cancel the load in progress.
REQ-008 SHALL have port base_addr  input  ADDR_W  first line address; captured on accepted start.
REQ-009 SHALL have port line_cnt_m1  input  ADDR_W  number of lines minus one; captured on accepted start.
REQ-010 SHALL have port in_valid  input  1  source word valid.
REQ-011 SHALL have port in_word  input  WORD_W  source word.
REQ-012 SHALL have port in_ready  output  1  controller accepts in_word this cycle.
REQ-013 SHALL have port iMem_WEPin  output  1  memory write enable.
REQ-014 SHALL have port WEAddress  output  ADDR_W  memory write line address.
REQ-015 SHALL have port idataWrite  output  WORD_W*WORDS  packed line written to memory.
REQ-016 SHALL have port core_hold  output  1  stalls the fetching core while the memory is being loaded.
REQ-017 SHALL have port busy  output  1  high in any state other than IDLE.
REQ-018 SHALL have port done  output  1  one-cycle pulse on successful completion.
REQ-019 SHALL have port checksum  output  WORD_W  XOR of all words accepted in the current or last load.

Function
REQ-020 SHALL implement FSM states IDLE, FILL, WRITE, DONE.
REQ-021 IDLE -> FILL on start=1 and abort=0; SHALL capture base_addr, line_cnt_m1, clear word index, line index, and checksum.
REQ-022 in_ready SHALL be 1 only in FILL; word accepted when in_valid & in_ready.
REQ-023 Word k of a line (k=0..WORDS-1, in acceptance order) SHALL be stored at idataWrite[WORD_W*k +: WORD_W].
REQ-024 On acceptance of word WORDS-1, FILL -> WRITE; word index returns to 0.
REQ-025 WRITE SHALL last exactly one cycle with iMem_WEPin=1 and WEAddress = (base + line index) mod 2^ADDR_W; wrap-around from 255 to 0 is legal.
REQ-026 iMem_WEPin SHALL be 0 in every state other than WRITE; idataWrite and WEAddress hold their values outside WRITE.
REQ-027 WRITE -> DONE when line index == line_cnt_m1, else line index increments and WRITE -> FILL.
REQ-028 DONE SHALL last one cycle with done=1, then -> IDLE.
REQ-029 core_hold SHALL equal busy.
REQ-030 Sustained throughput: one line per WORDS+1 cycles with in_valid held high; in_valid low in FILL stalls without side effects.
REQ-031 abort=1 in FILL, WRITE or DONE SHALL force IDLE next cycle; iMem_WEPin SHALL be 0 in that cycle; partial line discarded; done not pulsed.
REQ-032 abort and start both high in IDLE: abort wins, state stays IDLE.
REQ-033 start while busy SHALL be ignored.

Reset
REQ-034 reset_n=0 SHALL asynchronously force IDLE and drive in_ready, iMem_WEPin, core_hold, busy, done to 0 and WEAddress, idataWrite, checksum and all counters to 0.
REQ-035 Reset assertion mid-load SHALL discard the load with no write issued; after release, the block waits for a new start.

Configuration
REQ-036 With macro IMEM_LOAD_CHECKSUM_EN defined, checksum SHALL be XOR-accumulated on each accepted word and held after DONE until the next accepted start.
REQ-037 Without IMEM_LOAD_CHECKSUM_EN, checksum SHALL be constant 0 and no accumulator logic SHALL be present.

Verification
REQ-038 base_addr=0x10, line_cnt_m1=0, words 1..5 back-to-back -> one WEPin pulse, WEAddress=0x10, idataWrite word0=1 ... word4=5, done one cycle later.
REQ-039 base_addr=0xFE, line_cnt_m1=2, 15 words -> writes at 0xFE, 0xFF, 0x00; exactly three WEPin pulses, each 6 cycles apart.
REQ-040 in_valid toggled every other cycle during FILL -> same idataWrite as the back-to-back case; no extra WEPin pulses.
REQ-041 abort after word 3 of line 1 -> IDLE next cycle, no write for line 1, done=0, core_hold=0; start in same cycle as abort in IDLE -> ignored.
REQ-042 reset_n low for 1 cycle during WRITE -> all outputs 0 immediately; with IMEM_LOAD_CHECKSUM_EN, words 0x1,0x2,0x4,0x8,0x10 -> checksum=0x1F.
